// File: rtl/fft_seq_if.sv
// fft_seq_if: handshake and address-sequencing bundle between the FFT
// sequencer (master) and the read/write address generators plus the
// control logic that starts, stalls and aborts a transform (slave).
// Optional macro FFT_SEQ_STAGE_PULSE_EN adds the stage_done/stage_id pair.
interface fft_seq_if;
  // Control from the surrounding system
  logic       start;
  logic       abort;
  logic       hold;
  // Read-side issue
  logic       rd_en;
  logic [2:0] rd_stage;
  logic [3:0] rd_bfly;
  // Write-back side
  logic       wr_en;
  logic [2:0] wr_stage;
  logic [3:0] wr_bfly;
  // Status
  logic       busy;
  logic       done;
`ifdef FFT_SEQ_STAGE_PULSE_EN
  logic       stage_done;
  logic [2:0] stage_id;
`endif

  modport master (
    input  start,
    input  abort,
    input  hold,
    output rd_en,
    output rd_stage,
    output rd_bfly,
    output wr_en,
    output wr_stage,
    output wr_bfly,
    output busy,
`ifdef FFT_SEQ_STAGE_PULSE_EN
    output stage_done,
    output stage_id,
`endif
    output done
  );

  modport slave (
    output start,
    output abort,
    output hold,
    input  rd_en,
    input  rd_stage,
    input  rd_bfly,
    input  wr_en,
    input  wr_stage,
    input  wr_bfly,
    input  busy,
`ifdef FFT_SEQ_STAGE_PULSE_EN
    input  stage_done,
    input  stage_id,
`endif
    input  done
  );
endinterface

// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl: stage/butterfly sequencer for a 32-point radix-2 in-place FFT.
// Walks stage i (0..4) and butterfly j (0..15), issues (i, j) to the read
// address generator, replays every issued pair BFLY_LAT cycles later to the
// write-back side, and leaves a BFLY_LAT-cycle drain gap at each stage
// boundary so the first read of stage i+1 lands one cycle after the last
// write of stage i (synchronous-write memory, so the read sees new data).
// Every output is a register; the FSM state register is aligned with the
// cycle in which its outputs are visible (outputs decode the next state).
// Optional macro FFT_SEQ_STAGE_PULSE_EN adds stage_done/stage_id outputs.
module fft_seq_ctrl #(
  parameter int BFLY_LAT = 3,
  parameter int N_STAGES = 5,
  parameter int N_BFLY   = 16
) (
  input  logic      clk,
  input  logic      reset,
  fft_seq_if.master bus
);

  localparam logic [2:0] LAST_STAGE = 3'(N_STAGES - 1);
  localparam logic [3:0] LAST_BFLY  = 4'(N_BFLY - 1);
  localparam logic [3:0] DRAIN_LOAD = 4'(BFLY_LAT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_stage;
  logic [2:0] w_stage_nxt;
  logic [3:0] r_bfly;          // next butterfly to issue in the current stage
  logic [3:0] w_bfly_nxt;
  logic [3:0] r_drain;
  logic [3:0] w_drain_nxt;
  logic       w_try_issue;

  logic       r_rd_en;
  logic       w_rd_en_nxt;
  logic [2:0] r_rd_stage;
  logic [2:0] w_rd_stage_nxt;
  logic [3:0] r_rd_bfly;
  logic [3:0] w_rd_bfly_nxt;
  logic       r_busy;
  logic       w_busy_nxt;
  logic       r_done;
  logic       w_done_nxt;

  // The final butterfly of the stage is visible on the read port this cycle.
  logic       w_last_issued;
  assign w_last_issued = r_rd_en && (r_rd_bfly == LAST_BFLY);

  // Next-state, counter and registered-output decode; abort overrides all.
  always_comb begin
    w_state_nxt    = r_state;
    w_stage_nxt    = r_stage;
    w_bfly_nxt     = r_bfly;
    w_drain_nxt    = r_drain;
    w_try_issue    = 1'b0;
    w_rd_en_nxt    = 1'b0;
    w_rd_stage_nxt = r_rd_stage;
    w_rd_bfly_nxt  = r_rd_bfly;

    if (bus.abort) begin
      w_state_nxt = S_IDLE;
      w_stage_nxt = '0;
      w_bfly_nxt  = '0;
      w_drain_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            w_state_nxt = S_RUN;
            w_stage_nxt = '0;
            w_bfly_nxt  = '0;
            w_try_issue = 1'b1;
          end
        end
        S_RUN: begin
          if (w_last_issued) begin
            w_state_nxt = S_DRAIN;
            w_drain_nxt = DRAIN_LOAD;
          end else begin
            w_try_issue = 1'b1;
          end
        end
        S_DRAIN: begin
          // Drain counts down unconditionally; hold only gates issue.
          w_drain_nxt = r_drain - 4'd1;
          if (r_drain <= 4'd1) begin
            w_drain_nxt = '0;
            if (r_stage == LAST_STAGE) begin
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt = S_RUN;
              w_stage_nxt = r_stage + 3'd1;
              w_bfly_nxt  = '0;
              w_try_issue = 1'b1;
            end
          end
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
          w_stage_nxt = '0;
          w_bfly_nxt  = '0;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    // Issue slot for the coming cycle; hold freezes the butterfly counter.
    if (w_try_issue && !bus.hold) begin
      w_rd_en_nxt    = 1'b1;
      w_rd_stage_nxt = w_stage_nxt;
      w_rd_bfly_nxt  = w_bfly_nxt;
      w_bfly_nxt     = (w_bfly_nxt == LAST_BFLY) ? 4'd0 : (w_bfly_nxt + 4'd1);
    end

    w_busy_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // FSM state, counters and read-side/status output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_stage    <= '0;
      r_bfly     <= '0;
      r_drain    <= '0;
      r_rd_en    <= 1'b0;
      r_rd_stage <= '0;
      r_rd_bfly  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_stage    <= w_stage_nxt;
      r_bfly     <= w_bfly_nxt;
      r_drain    <= w_drain_nxt;
      r_rd_en    <= w_rd_en_nxt;
      r_rd_stage <= w_rd_stage_nxt;
      r_rd_bfly  <= w_rd_bfly_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Write-side delay line: element k holds the read issue from k+1 cycles
  // ago, so the last element is the write port. Data fields only capture on
  // a valid entry, which keeps wr_stage/wr_bfly at the last written pair.
  logic       r_dl_vld  [BFLY_LAT];
  logic [2:0] r_dl_stg  [BFLY_LAT];
  logic [3:0] r_dl_bfly [BFLY_LAT];

  // Shift the delay line every cycle regardless of hold; abort kills it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < BFLY_LAT; k++) begin
        r_dl_vld[k]  <= 1'b0;
        r_dl_stg[k]  <= '0;
        r_dl_bfly[k] <= '0;
      end
    end else begin
      r_dl_vld[0] <= r_rd_en && !bus.abort;
      if (r_rd_en && !bus.abort) begin
        r_dl_stg[0]  <= r_rd_stage;
        r_dl_bfly[0] <= r_rd_bfly;
      end
      for (int k = 1; k < BFLY_LAT; k++) begin
        r_dl_vld[k] <= r_dl_vld[k-1] && !bus.abort;
        if (r_dl_vld[k-1] && !bus.abort) begin
          r_dl_stg[k]  <= r_dl_stg[k-1];
          r_dl_bfly[k] <= r_dl_bfly[k-1];
        end
      end
    end
  end

  assign bus.rd_en    = r_rd_en;
  assign bus.rd_stage = r_rd_stage;
  assign bus.rd_bfly  = r_rd_bfly;
  assign bus.wr_en    = r_dl_vld[BFLY_LAT-1];
  assign bus.wr_stage = r_dl_stg[BFLY_LAT-1];
  assign bus.wr_bfly  = r_dl_bfly[BFLY_LAT-1];
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

`ifdef FFT_SEQ_STAGE_PULSE_EN
  // Entry about to move into the write port on the next edge.
  logic       w_tap_vld;
  logic [2:0] w_tap_stg;
  logic [3:0] w_tap_bfly;
  logic       w_tap_last;

  if (BFLY_LAT == 1) begin : g_tap_rd
    assign w_tap_vld  = r_rd_en;
    assign w_tap_stg  = r_rd_stage;
    assign w_tap_bfly = r_rd_bfly;
  end else begin : g_tap_dl
    assign w_tap_vld  = r_dl_vld[BFLY_LAT-2];
    assign w_tap_stg  = r_dl_stg[BFLY_LAT-2];
    assign w_tap_bfly = r_dl_bfly[BFLY_LAT-2];
  end

  assign w_tap_last = w_tap_vld && (w_tap_bfly == LAST_BFLY) && !bus.abort;

  logic       r_stage_done;
  logic [2:0] r_stage_id;

  // Stage-complete pulse aligned with the last write of each stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stage_done <= 1'b0;
      r_stage_id   <= '0;
    end else begin
      r_stage_done <= w_tap_last;
      if (w_tap_last) begin
        r_stage_id <= w_tap_stg;
      end
    end
  end

  assign bus.stage_done = r_stage_done;
  assign bus.stage_id   = r_stage_id;
`endif

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// tb_fft_seq_ctrl: directed bench for fft_seq_ctrl at BFLY_LAT=3.
// Expected read schedule: cycle t (1 = first rd_en) maps to k=t-1,
// stage=k/19, bfly=k%19, valid when bfly<16 and stage<5; a hold window
// shifts everything after it. Writes are the read schedule 3 cycles later.
module tb_fft_seq_ctrl;
  localparam int LAT = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  fft_seq_if bus();

  fft_seq_ctrl #(.BFLY_LAT(LAT), .N_STAGES(5), .N_BFLY(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference schedule; hold high in cycles hs..hs+hl-1 blanks reads hs+1..hs+hl.
  function automatic void exp_rd(input int t, input int hs, input int hl,
                                 output logic v, output logic [2:0] s,
                                 output logic [3:0] b);
    int tt;
    int k;
    v = 1'b0;
    s = '0;
    b = '0;
    if (t < 1) return;
    if (hl > 0 && t >= hs + 1 && t <= hs + hl) return;
    tt = (hl > 0 && t > hs + hl) ? t - hl : t;
    k  = tt - 1;
    if ((k / 19) < 5 && (k % 19) < 16) begin
      v = 1'b1;
      s = 3'(k / 19);
      b = 4'(k % 19);
    end
  endfunction

  task automatic test_reset();
    bus.start = 1'b1;
    bus.abort = 1'b0;
    bus.hold  = 1'b0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({bus.rd_en, bus.rd_stage, bus.rd_bfly, bus.wr_en, bus.wr_stage,
         bus.wr_bfly, bus.busy, bus.done} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rd=%0b(%0d,%0d) wr=%0b(%0d,%0d) busy=%0b done=%0b, want all 0",
               bus.rd_en, bus.rd_stage, bus.rd_bfly, bus.wr_en, bus.wr_stage,
               bus.wr_bfly, bus.busy, bus.done);
    end
`ifdef FFT_SEQ_STAGE_PULSE_EN
    n_tests++;
    if (bus.stage_done !== 1'b0 || bus.stage_id !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_stage_pulse: got %0b/%0d want 0/0", bus.stage_done, bus.stage_id);
    end
`endif
    @(posedge clk); #1;
    reset     = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (bus.rd_en !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_after_reset: got rd_en=%0b busy=%0b done=%0b want 0 0 0",
                 bus.rd_en, bus.busy, bus.done);
      end
    end
    @(posedge clk); #1;
  endtask

  // Full transform: hold window (hs, hl) and two optional stray start pulses.
  task automatic test_transform(input string name, input int hs, input int hl,
                                input int sp1, input int sp2);
    int         done_t;
    int         n_rd;
    int         n_wr;
    int         n_done;
    int         n_pulse;
    logic       ev;
    logic [2:0] es;
    logic [3:0] eb;
    logic       wv;
    logic [2:0] ws;
    logic [3:0] wb;
    logic       have_w;
    logic [2:0] lw_s;
    logic [3:0] lw_b;
    done_t  = 96 + hl;
    n_rd    = 0;
    n_wr    = 0;
    n_done  = 0;
    n_pulse = 0;
    have_w  = 1'b0;
    lw_s    = '0;
    lw_b    = '0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int t = 1; t <= done_t + 8; t++) begin
      bus.hold  = (hl > 0 && t >= hs && t < hs + hl);
      bus.start = (t == sp1 || t == sp2);
      @(negedge clk);
      if (bus.rd_en === 1'b1) n_rd++;
      if (bus.wr_en === 1'b1) n_wr++;
      if (bus.done === 1'b1) n_done++;
      exp_rd(t, hs, hl, ev, es, eb);
      n_tests++;
      if (bus.rd_en !== ev || (ev && (bus.rd_stage !== es || bus.rd_bfly !== eb))) begin
        n_fail++;
        $display("FAIL %s rd t=%0d: got en=%0b (%0d,%0d) want en=%0b (%0d,%0d)",
                 name, t, bus.rd_en, bus.rd_stage, bus.rd_bfly, ev, es, eb);
      end
      exp_rd(t - LAT, hs, hl, wv, ws, wb);
      n_tests++;
      if (wv) begin
        if (bus.wr_en !== 1'b1 || bus.wr_stage !== ws || bus.wr_bfly !== wb) begin
          n_fail++;
          $display("FAIL %s wr t=%0d: got en=%0b (%0d,%0d) want en=1 (%0d,%0d)",
                   name, t, bus.wr_en, bus.wr_stage, bus.wr_bfly, ws, wb);
        end
        have_w = 1'b1;
        lw_s   = ws;
        lw_b   = wb;
      end else if (bus.wr_en !== 1'b0 ||
                   (have_w && (bus.wr_stage !== lw_s || bus.wr_bfly !== lw_b))) begin
        n_fail++;
        $display("FAIL %s wr_idle t=%0d: got en=%0b (%0d,%0d) want en=0 holding (%0d,%0d)",
                 name, t, bus.wr_en, bus.wr_stage, bus.wr_bfly, lw_s, lw_b);
      end
      n_tests++;
      if (bus.done !== (t == done_t) || bus.busy !== (t < done_t)) begin
        n_fail++;
        $display("FAIL %s status t=%0d: got done=%0b busy=%0b want done=%0b busy=%0b",
                 name, t, bus.done, bus.busy, (t == done_t), (t < done_t));
      end
`ifdef FFT_SEQ_STAGE_PULSE_EN
      if (bus.stage_done === 1'b1) n_pulse++;
      n_tests++;
      if (bus.stage_done !== (wv && wb == 4'd15) ||
          (wv && wb == 4'd15 && bus.stage_id !== ws)) begin
        n_fail++;
        $display("FAIL %s stage_pulse t=%0d: got %0b id=%0d want %0b id=%0d",
                 name, t, bus.stage_done, bus.stage_id, (wv && wb == 4'd15), ws);
      end
`endif
      @(posedge clk); #1;
    end
    bus.hold  = 1'b0;
    bus.start = 1'b0;
    n_tests++;
    if (n_rd != 80 || n_wr != 80 || n_done != 1) begin
      n_fail++;
      $display("FAIL %s totals: got rd=%0d wr=%0d done=%0d want 80 80 1",
               name, n_rd, n_wr, n_done);
    end
`ifdef FFT_SEQ_STAGE_PULSE_EN
    n_tests++;
    if (n_pulse != 5) begin
      n_fail++;
      $display("FAIL %s pulse_count: got %0d want 5", name, n_pulse);
    end
`endif
  endtask

  task automatic test_abort();
    // abort wins over start in IDLE
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.rd_en !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_over_start: got rd_en=%0b busy=%0b want 0 0", bus.rd_en, bus.busy);
    end
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int t = 1; t <= 65; t++) begin
      bus.abort = (t == 65);
      @(negedge clk);
      if (t == 65) begin
        n_tests++;
        if (bus.rd_en !== 1'b1 || bus.rd_stage !== 3'd3 || bus.rd_bfly !== 4'd7 ||
            bus.wr_en !== 1'b1 || bus.wr_stage !== 3'd3 || bus.wr_bfly !== 4'd4) begin
          n_fail++;
          $display("FAIL abort_point: got rd=%0b(%0d,%0d) wr=%0b(%0d,%0d) want rd=1(3,7) wr=1(3,4)",
                   bus.rd_en, bus.rd_stage, bus.rd_bfly, bus.wr_en, bus.wr_stage, bus.wr_bfly);
        end
      end
      @(posedge clk); #1;
    end
    bus.abort = 1'b0;
    for (int t = 66; t <= 105; t++) begin
      @(negedge clk);
      n_tests++;
      if (bus.rd_en !== 1'b0 || bus.wr_en !== 1'b0 || bus.busy !== 1'b0 ||
          bus.done !== 1'b0 || bus.wr_stage !== 3'd3 || bus.wr_bfly !== 4'd4) begin
        n_fail++;
        $display("FAIL after_abort t=%0d: got rd=%0b wr=%0b(%0d,%0d) busy=%0b done=%0b want 0 0(3,4) 0 0",
                 t, bus.rd_en, bus.wr_en, bus.wr_stage, bus.wr_bfly, bus.busy, bus.done);
      end
`ifdef FFT_SEQ_STAGE_PULSE_EN
      n_tests++;
      if (bus.stage_done !== 1'b0) begin
        n_fail++;
        $display("FAIL after_abort_pulse t=%0d: got %0b want 0", t, bus.stage_done);
      end
`endif
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int t = 1; t <= 37; t++) begin
      @(negedge clk);
      if (t == 37) begin
        n_tests++;
        if (bus.busy !== 1'b1 || bus.rd_en !== 1'b0 || bus.wr_en !== 1'b1 ||
            bus.wr_stage !== 3'd1 || bus.wr_bfly !== 4'd14) begin
          n_fail++;
          $display("FAIL drain_point: got busy=%0b rd=%0b wr=%0b(%0d,%0d) want 1 0 1(1,14)",
                   bus.busy, bus.rd_en, bus.wr_en, bus.wr_stage, bus.wr_bfly);
        end
      end else begin
        @(posedge clk); #1;
      end
    end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({bus.rd_en, bus.rd_stage, bus.rd_bfly, bus.wr_en, bus.wr_stage,
         bus.wr_bfly, bus.busy, bus.done} !== 18'd0) begin
      n_fail++;
      $display("FAIL async_reset: got rd=%0b(%0d,%0d) wr=%0b(%0d,%0d) busy=%0b done=%0b want all 0",
               bus.rd_en, bus.rd_stage, bus.rd_bfly, bus.wr_en, bus.wr_stage,
               bus.wr_bfly, bus.busy, bus.done);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got wr=%0b busy=%0b rd=%0b want 0 0 0",
               bus.wr_en, bus.busy, bus.rd_en);
    end
    @(posedge clk); #1;
    test_transform("after_async_reset", 0, 0, -1, -1);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.hold  = 1'b0;
    test_reset();
    test_transform("default", 0, 0, -1, -1);
    test_transform("hold", 5, 4, -1, -1);
    test_transform("start_ignored", 0, 0, 40, 96);
    test_transform("after_restart", 0, 0, -1, -1);
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
